// File: rtl/key_scanner.sv
// Password-lock key front end: synchronises and debounces four buttons plus the
// Change switch, and turns one accepted single-key press into a KeyValue/KeyPress pair.
module key_scanner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int PRESS_CYCLES    = 4,
  parameter int CNT_W           = 15
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [3:0] Btn,
  input  logic       ChangeRaw,
  output logic       KeyPress,
  output logic [1:0] KeyValue,
  output logic       Change,
  output logic       KeyErr,
  output logic       Busy
);

  // state   | meaning
  // IDLE    | no key accepted, waiting for a debounced key
  // SETUP   | KeyValue latched, one cycle ahead of the strobe
  // PRESS   | KeyPress high, strobe counter running down
  // RELEASE | strobe done, waiting for all keys up
  // REJECT  | chord seen, waiting for all keys up
  typedef enum logic [2:0] {IDLE, SETUP, PRESS, RELEASE, REJECT} state_t;

  localparam int PW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]    PR_LOAD = PW'(PRESS_CYCLES - 1);

  logic [4:0]       sync1_q, sync2_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];

  state_t     state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0] kv_q, kv_d;
  logic       press_q, press_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic [3:0] key;
  logic       one_hot, multi;
  logic [1:0] key_idx;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      state_q <= IDLE;
      pcnt_q  <= '0;
      kv_q    <= '0;
      press_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= {ChangeRaw, Btn};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      kv_q    <= kv_d;
      press_q <= press_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // The counter counts mismatching cycles; the DEBOUNCE_CYCLES-th one commits the level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_TC) deb_d[i] = sync2_q[i];
        else                   cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign key     = deb_q[3:0];
  assign one_hot = (key != 4'd0) && ((key & (key - 4'd1)) == 4'd0);
  assign multi   = (key != 4'd0) && !one_hot;

  always_comb begin
    key_idx = 2'd0;
    if (key[1]) key_idx = 2'd1;
    if (key[2]) key_idx = 2'd2;
    if (key[3]) key_idx = 2'd3;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    kv_d    = kv_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          kv_d    = key_idx;
          state_d = SETUP;
        end else if (multi) begin
          err_d   = 1'b1;
          state_d = REJECT;
        end
      end
      SETUP: begin
        pcnt_d  = PR_LOAD;
        state_d = PRESS;
      end
      PRESS: begin
        if (pcnt_q == '0) state_d = RELEASE;
        else              pcnt_d  = pcnt_q - 1'b1;
      end
      RELEASE, REJECT: begin
        if (key == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    press_d = (state_d == PRESS);
    busy_d  = (state_d != IDLE);
  end

  assign KeyPress = press_q;
  assign KeyValue = kv_q;
  assign Change   = deb_q[4];
  assign KeyErr   = err_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner with short debounce and strobe lengths.
module tb_key_scanner;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic [3:0] Btn = 4'd0;
  logic       ChangeRaw = 1'b0;
  logic       KeyPress;
  logic [1:0] KeyValue;
  logic       Change;
  logic       KeyErr;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  key_scanner #(.DEBOUNCE_CYCLES(4), .PRESS_CYCLES(3), .CNT_W(15)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .Btn(Btn), .ChangeRaw(ChangeRaw),
    .KeyPress(KeyPress), .KeyValue(KeyValue), .Change(Change),
    .KeyErr(KeyErr), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0; Btn = 4'd0; ChangeRaw = 1'b0;
    repeat (3) cyc();
    checks++; if (KeyPress !== 1'b0) begin errors++; $display("FAIL reset_keypress got %b want 0", KeyPress); end
    checks++; if (KeyValue !== 2'd0) begin errors++; $display("FAIL reset_keyvalue got %0d want 0", KeyValue); end
    checks++; if (Change !== 1'b0) begin errors++; $display("FAIL reset_change got %b want 0", Change); end
    checks++; if (KeyErr !== 1'b0) begin errors++; $display("FAIL reset_keyerr got %b want 0", KeyErr); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    CLR_N = 1'b1;
    cyc();
    Btn = 4'b0100;
    repeat (9) cyc();
    checks++; if (KeyPress !== 1'b1) begin errors++; $display("FAIL midpress_strobe got %b want 1", KeyPress); end
    checks++; if (KeyValue !== 2'd2) begin errors++; $display("FAIL midpress_value got %0d want 2", KeyValue); end
    #2 CLR_N = 1'b0;
    #1;
    checks++; if (KeyPress !== 1'b0) begin errors++; $display("FAIL async_reset_keypress got %b want 0", KeyPress); end
    checks++; if (KeyValue !== 2'd0) begin errors++; $display("FAIL async_reset_keyvalue got %0d want 0", KeyValue); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b want 0", Busy); end
    Btn = 4'd0;
    cyc();
    #2 CLR_N = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      checks++;
      if (KeyPress !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d got press=%b busy=%b want 0 0", n, KeyPress, Busy);
      end
    end
  endtask

  task automatic test_clean_press();
    int strobes;
    logic prev;
    strobes = 0; prev = 1'b0;
    Btn = 4'b0100;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n == 6) begin
        checks++; if (KeyValue !== 2'd0) begin errors++; $display("FAIL clean_value_early got %0d want 0", KeyValue); end
      end
      if (n == 7) begin
        checks++; if (KeyValue !== 2'd2) begin errors++; $display("FAIL clean_value_setup got %0d want 2", KeyValue); end
      end
      checks++;
      if (KeyPress !== (n >= 8 && n <= 10)) begin
        errors++;
        $display("FAIL clean_strobe cycle %0d got %b want %b", n, KeyPress, (n >= 8 && n <= 10));
      end
      if (KeyPress && !prev) strobes++;
      prev = KeyPress;
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL clean_strobe_count got %0d want 1", strobes); end
    Btn = 4'd0;
    for (int n = 1; n <= 7; n++) begin
      cyc();
      if (n == 6) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL release_busy_hold got %b want 1", Busy); end
      end
      if (n == 7) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL release_busy_drop got %b want 0", Busy); end
      end
    end
  endtask

  task automatic test_bounce();
    int strobes;
    logic prev;
    logic early;
    strobes = 0; prev = 1'b0; early = 1'b0;
    for (int p = 0; p < 6; p++) begin
      Btn = (p % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        cyc();
        if (KeyPress !== 1'b0 || Busy !== 1'b0) early = 1'b1;
      end
    end
    checks++; if (early) begin errors++; $display("FAIL bounce_quiet got activity want none"); end
    Btn = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n == 7) begin
        checks++; if (KeyPress !== 1'b0) begin errors++; $display("FAIL bounce_setup_press got %b want 0", KeyPress); end
      end
      if (n == 8) begin
        checks++; if (KeyPress !== 1'b1) begin errors++; $display("FAIL bounce_strobe got %b want 1", KeyPress); end
      end
      if (KeyPress && !prev) strobes++;
      prev = KeyPress;
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL bounce_strobe_count got %0d want 1", strobes); end
    checks++; if (KeyValue !== 2'd1) begin errors++; $display("FAIL bounce_value got %0d want 1", KeyValue); end
    Btn = 4'd0;
    repeat (10) cyc();
  endtask

  task automatic test_chord();
    int strobes;
    logic prev;
    logic bad;
    strobes = 0; prev = 1'b0;
    Btn = 4'b1001;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      checks++;
      if (KeyErr !== (n == 7)) begin
        errors++;
        $display("FAIL chord_keyerr cycle %0d got %b want %b", n, KeyErr, (n == 7));
      end
      checks++;
      if (KeyPress !== 1'b0 || KeyValue !== 2'd1) begin
        errors++;
        $display("FAIL chord_no_strobe cycle %0d got press=%b value=%0d want 0 1", n, KeyPress, KeyValue);
      end
    end
    Btn = 4'b0001;
    bad = 1'b0;
    repeat (14) begin
      cyc();
      if (KeyPress !== 1'b0 || KeyValue !== 2'd1 || Busy !== 1'b1 || KeyErr !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL chord_decay got activity want held reject"); end
    Btn = 4'd0;
    repeat (8) cyc();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL chord_release_busy got %b want 0", Busy); end
    Btn = 4'b1000;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (n == 7) begin
        checks++; if (KeyValue !== 2'd3) begin errors++; $display("FAIL chord_next_value got %0d want 3", KeyValue); end
      end
      checks++;
      if (KeyPress !== (n >= 8 && n <= 10)) begin
        errors++;
        $display("FAIL chord_next_strobe cycle %0d got %b want %b", n, KeyPress, (n >= 8 && n <= 10));
      end
      if (KeyPress && !prev) strobes++;
      prev = KeyPress;
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL chord_next_count got %0d want 1", strobes); end
    Btn = 4'd0;
    repeat (10) cyc();
  endtask

  task automatic test_held_second();
    int strobes;
    logic prev;
    strobes = 0; prev = 1'b0;
    Btn = 4'b0001;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (n == 9) Btn = 4'b0101;
      if (KeyPress && !prev) strobes++;
      prev = KeyPress;
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL held_strobe_count got %0d want 1", strobes); end
    checks++; if (KeyValue !== 2'd0) begin errors++; $display("FAIL held_value got %0d want 0", KeyValue); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL held_busy got %b want 1", Busy); end
    Btn = 4'd0;
    for (int n = 1; n <= 14; n++) begin
      cyc();
      if (KeyPress && !prev) strobes++;
      prev = KeyPress;
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL held_after_release_count got %0d want 1", strobes); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL held_release_busy got %b want 0", Busy); end
  endtask

  task automatic test_change();
    logic leaked;
    leaked = 1'b0;
    ChangeRaw = 1'b1;
    repeat (3) cyc();
    ChangeRaw = 1'b0;
    repeat (12) begin
      cyc();
      if (Change !== 1'b0) leaked = 1'b1;
    end
    checks++; if (leaked) begin errors++; $display("FAIL change_glitch got 1 want 0"); end
    ChangeRaw = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 5) begin
        checks++; if (Change !== 1'b0) begin errors++; $display("FAIL change_rise_early got %b want 0", Change); end
      end
      if (n == 6) begin
        checks++; if (Change !== 1'b1) begin errors++; $display("FAIL change_rise got %b want 1", Change); end
      end
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL change_fsm_busy got %b want 0", Busy); end
    ChangeRaw = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (n == 5) begin
        checks++; if (Change !== 1'b1) begin errors++; $display("FAIL change_fall_early got %b want 1", Change); end
      end
      if (n == 6) begin
        checks++; if (Change !== 1'b0) begin errors++; $display("FAIL change_fall got %b want 0", Change); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_held_second();
    test_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
